us_pulse_detector: RTL and testbench
====================================

US_PULSE_DETECTOR -- requirements
Module: us_pulse_detector

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the input synchronizer depth (allowed 2..4).
REQ-002 The block SHALL have parameter MIN_HIGH, default 8, meaning the consecutive synchronized-high cycles needed to qualify a pulse (allowed 1..255).
REQ-003 The block SHALL have parameter HOLDOFF, default 2000, meaning the dead-time cycles after a detection (allowed 0..65535).
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit: detection enable.
REQ-007 The block SHALL have port piezo_in, input, 1 bit: raw asynchronous piezo receiver comparator output.
REQ-008 The block SHALL have port clr_count, input, 1 bit: synchronous clear of event_count.
REQ-009 The block SHALL have port pulse_out, output, 1 bit: single-cycle qualified-pulse strobe to the PTP master/slave input.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port event_count, output, 16 bits: the count of pulse_out strobes.
REQ-012 The block SHALL have port timestamp, output, 32 bits: the free-running time captured at the last detection.

Function
REQ-013 piezo_in SHALL pass through SYNC_STAGES flops; s denotes the last flop's output; no other logic SHALL sample piezo_in.
REQ-014 The FSM SHALL have states IDLE, QUALIFY, HOLD, WAIT_LOW.
REQ-015 IDLE: when enable=1 and s=1, go to QUALIFY with width counter=1.
REQ-016 QUALIFY: s=1 increments the width counter; s=0 returns to IDLE with no strobe (glitch rejected).
REQ-017 When the width counter reaches MIN_HIGH, pulse_out SHALL be high for exactly the next cycle and the FSM SHALL enter HOLD (or WAIT_LOW if HOLDOFF=0).
REQ-018 Latency: with piezo_in stable high before edge E0, pulse_out SHALL be high in the cycle after edge E0+SYNC_STAGES+MIN_HIGH-1.
REQ-019 HOLD: ignore s for exactly HOLDOFF cycles, then go to WAIT_LOW.
REQ-020 WAIT_LOW: go to IDLE on the first cycle with s=0, so that a long pulse yields one strobe.
REQ-021 enable=0 SHALL force IDLE on the next edge from any state, clear the width and holdoff counters, and suppress pulse_out that cycle; enable takes priority over all other events.
REQ-022 event_count SHALL increment on each pulse_out and wrap from 0xFFFF to 0x0000.
REQ-023 clr_count SHALL set event_count to 0; if it coincides with a pulse_out, event_count SHALL become 1.
REQ-024 At most one pulse_out SHALL occur per MIN_HIGH+HOLDOFF+1 cycles.

Reset
REQ-025 reset_n=0 SHALL asynchronously clear the synchronizer flops, FSM (IDLE), width and holdoff counters, pulse_out=0, busy=0, event_count=0, timestamp=0, and the free-running counter; a reset mid-qualification SHALL produce no strobe.

Configuration
REQ-026 With macro US_DET_TIMESTAMP_EN defined, a 32-bit free-running counter SHALL increment every cycle from reset, wrap 0xFFFFFFFF to 0, and its value SHALL load into timestamp on the edge that asserts pulse_out.
REQ-027 Without US_DET_TIMESTAMP_EN, the counter SHALL not exist and timestamp SHALL be constant 0.

Verification
REQ-028 Default parameters, enable=1, piezo_in high for 20 cycles -> one pulse_out 9 edges after first sampling edge, event_count=1, busy high until HOLD done and s=0.
REQ-029 piezo_in high 5 cycles (<MIN_HIGH) -> no pulse_out, FSM back to IDLE, event_count=0.
REQ-030 Two qualified pulses 500 cycles apart (HOLDOFF=2000) -> only first strobes; pulses 2100 cycles apart -> two strobes, event_count=2.
REQ-031 enable dropped in QUALIFY at width 6 -> no strobe, IDLE next edge; reset_n pulsed low in HOLD -> all outputs 0 immediately.
REQ-032 Preload event_count to 0xFFFF via 65535 pulses (HOLDOFF=0, MIN_HIGH=1) then one more -> 0x0000; clr_count same cycle as strobe -> 1.
REQ-033 With US_DET_TIMESTAMP_EN, first strobe at cycle 1000 after reset release -> timestamp=999 (counter value at asserting edge); without macro -> timestamp=0.

Source files
------------

// File: rtl/us_pulse_detector.sv
// Ultrasonic piezo pulse detector: synchronizer, width qualifier, holdoff and event counter.
// Optional macro US_DET_TIMESTAMP_EN adds a free-running counter captured into timestamp.
module us_pulse_detector #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MIN_HIGH    = 8,
   parameter int unsigned HOLDOFF     = 2000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        piezo_in,
   input  logic        clr_count,
   output logic        pulse_out,
   output logic        busy,
   output logic [15:0] event_count,
   output logic [31:0] timestamp
);

   typedef enum logic [1:0] {IDLE, QUALIFY, HOLD, WAIT_LOW} state_t;

   localparam logic [7:0]  WIDTH_LAST = 8'(MIN_HIGH - 1);
   localparam logic [15:0] HOLD_LAST  = (HOLDOFF > 0) ? 16'(HOLDOFF - 1) : 16'd0;
   localparam state_t      AFTER_HIT  = (HOLDOFF == 0) ? WAIT_LOW : HOLD;

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   state_t                 state, state_next;
   logic [7:0]             width, width_next;
   logic [15:0]            hold_cnt, hold_next;
   logic                   strobe;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) sync <= '0;
      else          sync <= {sync[SYNC_STAGES-2:0], piezo_in};
   end

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         width     <= '0;
         hold_cnt  <= '0;
         pulse_out <= 1'b0;
      end else begin
         state     <= state_next;
         width     <= width_next;
         hold_cnt  <= hold_next;
         pulse_out <= strobe;
      end
   end

   // strobe marks the edge on which the width counter reaches MIN_HIGH
   always_comb begin
      state_next = state;
      width_next = width;
      hold_next  = hold_cnt;
      strobe     = 1'b0;
      if (!enable) begin
         state_next = IDLE;
         width_next = '0;
         hold_next  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (s) begin
                  if (MIN_HIGH == 1) begin
                     strobe     = 1'b1;
                     width_next = '0;
                     hold_next  = '0;
                     state_next = AFTER_HIT;
                  end else begin
                     width_next = 8'd1;
                     state_next = QUALIFY;
                  end
               end
            end
            QUALIFY: begin
               if (!s) begin
                  width_next = '0;
                  state_next = IDLE;
               end else if (width == WIDTH_LAST) begin
                  strobe     = 1'b1;
                  width_next = '0;
                  hold_next  = '0;
                  state_next = AFTER_HIT;
               end else begin
                  width_next = width + 8'd1;
               end
            end
            HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  hold_next  = '0;
                  state_next = WAIT_LOW;
               end else begin
                  hold_next = hold_cnt + 16'd1;
               end
            end
            WAIT_LOW: begin
               if (!s) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

   // counting on the registered strobe lets a coincident clear keep this event
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)       event_count <= '0;
      else if (clr_count) event_count <= {15'd0, pulse_out};
      else if (pulse_out) event_count <= event_count + 16'd1;
   end

`ifdef US_DET_TIMESTAMP_EN
   logic [31:0] free_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         free_cnt  <= '0;
         timestamp <= '0;
      end else begin
         free_cnt <= free_cnt + 32'd1;
         if (strobe) timestamp <= free_cnt;
      end
   end
`else
   assign timestamp = '0;
`endif

endmodule

// File: tb/tb_us_pulse_detector.sv
// Self-checking bench for us_pulse_detector: strobe scoreboard on the default instance,
// plus a fast MIN_HIGH=1/HOLDOFF=0 instance for event_count wrap.
module tb_us_pulse_detector;

   localparam int unsigned SS = 2;
   localparam int unsigned MH = 8;
   localparam int unsigned HO = 2000;
`ifdef US_DET_TIMESTAMP_EN
   localparam bit TS_EN = 1'b1;
`else
   localparam bit TS_EN = 1'b0;
`endif

   logic        clock = 1'b0, reset_n = 1'b0, enable = 1'b0, piezo_in = 1'b0, clr_count = 1'b0;
   logic        pulse_out, busy;
   logic [15:0] event_count;
   logic [31:0] timestamp;

   logic        clk2 = 1'b0, piezo2 = 1'b0;
   logic        pulse2, busy2;
   logic [15:0] count2;
   logic [31:0] ts2;

   int unsigned checks = 0, errors = 0;
   int unsigned cyc = 0;
   int unsigned exp_q[$];
   int unsigned obs_cyc[$];
   logic [31:0] obs_ts[$];
   logic [15:0] exp_count = '0;

   always #5 clock = ~clock;
   always #2 clk2 = ~clk2;

   us_pulse_detector #(.SYNC_STAGES(SS), .MIN_HIGH(MH), .HOLDOFF(HO)) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .piezo_in(piezo_in),
      .clr_count(clr_count), .pulse_out(pulse_out), .busy(busy),
      .event_count(event_count), .timestamp(timestamp)
   );

   us_pulse_detector #(.SYNC_STAGES(2), .MIN_HIGH(1), .HOLDOFF(0)) u_wrap (
      .clock(clk2), .reset_n(reset_n), .enable(1'b1), .piezo_in(piezo2),
      .clr_count(1'b0), .pulse_out(pulse2), .busy(busy2),
      .event_count(count2), .timestamp(ts2)
   );

   // cyc = number of rising edges since reset release
   always @(posedge clock or negedge reset_n)
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;

   always @(negedge clock)
      if (reset_n && pulse_out) begin
         obs_cyc.push_back(cyc);
         obs_ts.push_back(timestamp);
      end

   task automatic ticks(input int unsigned n);
      repeat (n) @(negedge clock);
   endtask

   task automatic ticks_to(input int unsigned target);
      if (target > cyc) repeat (target - cyc) @(negedge clock);
   endtask

   // Raise piezo_in at the current negedge; if it should qualify, queue the expected strobe edge.
   task automatic start_pulse(input bit expect_hit);
      piezo_in = 1'b1;
      if (expect_hit) begin
         exp_q.push_back(cyc + SS + MH);
         exp_count = exp_count + 16'd1;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      ticks(3);
      checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", pulse_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (event_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h want 0000", event_count); end
      checks++; if (timestamp !== 32'h0) begin errors++; $display("FAIL reset_ts: got %h want 0", timestamp); end
      reset_n = 1'b1;
      enable  = 1'b1;
   endtask

   task automatic test_glitch;
      ticks(5);
      start_pulse(1'b0);
      ticks(5);
      piezo_in = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_mid: got %b want 1", busy); end
      ticks(6);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: busy got %b want 0", busy); end
      checks++; if (event_count !== exp_count) begin errors++; $display("FAIL glitch_count: got %h want %h", event_count, exp_count); end
      checks++; if (obs_cyc.size() != 0) begin errors++; $display("FAIL glitch_strobe: got %0d strobes want 0", obs_cyc.size()); obs_cyc.delete(); obs_ts.delete(); end
   endtask

   task automatic test_single_pulse;
      int unsigned e, o;
      logic [31:0] t;
      ticks_to(990);
      start_pulse(1'b1);
      ticks(20);
      piezo_in = 1'b0;
      checks++; if (event_count !== exp_count) begin errors++; $display("FAIL single_count: got %h want %h", event_count, exp_count); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_cyc.size() == 0) begin
            errors++; $display("FAIL single_strobe: missing, want edge %0d", e);
         end else begin
            o = obs_cyc.pop_front(); t = obs_ts.pop_front();
            if (o !== e) begin errors++; $display("FAIL single_strobe: edge %0d want %0d", o, e); end
            checks++;
            if (t !== (TS_EN ? 32'(e - 1) : 32'd0)) begin errors++; $display("FAIL single_ts: got %0d want %0d", t, TS_EN ? e - 1 : 0); end
         end
      end
      checks++; if (obs_cyc.size() != 0) begin errors++; $display("FAIL single_extra: got %0d extra strobes want 0", obs_cyc.size()); obs_cyc.delete(); obs_ts.delete(); end
      ticks_to(1000 + HO);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_wait_low: got %b want 1", busy); end
      ticks(1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b want 0", busy); end
   endtask

   task automatic test_holdoff;
      int unsigned c, e, o;
      logic [31:0] t;
      ticks(5);
      c = cyc;
      start_pulse(1'b1);
      ticks(20); piezo_in = 1'b0;
      ticks_to(c + 500);
      start_pulse(1'b0);
      ticks(20); piezo_in = 1'b0;
      ticks_to(c + 2100);
      start_pulse(1'b1);
      ticks(20); piezo_in = 1'b0;
      ticks_to(c + 2110 + HO + 2);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL holdoff_idle: busy got %b want 0", busy); end
      checks++; if (event_count !== exp_count) begin errors++; $display("FAIL holdoff_count: got %h want %h", event_count, exp_count); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_cyc.size() == 0) begin
            errors++; $display("FAIL holdoff_strobe: missing, want edge %0d", e);
         end else begin
            o = obs_cyc.pop_front(); t = obs_ts.pop_front();
            if (o !== e) begin errors++; $display("FAIL holdoff_strobe: edge %0d want %0d", o, e); end
            checks++;
            if (t !== (TS_EN ? 32'(e - 1) : 32'd0)) begin errors++; $display("FAIL holdoff_ts: got %0d want %0d", t, TS_EN ? e - 1 : 0); end
         end
      end
      checks++; if (obs_cyc.size() != 0) begin errors++; $display("FAIL holdoff_extra: got %0d extra strobes want 0", obs_cyc.size()); obs_cyc.delete(); obs_ts.delete(); end
   endtask

   // Drop enable at width 6 and, separately, at width 7 (one edge before the strobe would fire).
   task automatic test_enable_drop;
      int unsigned drops[2] = '{8, 9};
      foreach (drops[k]) begin
         ticks(5);
         start_pulse(1'b0);
         ticks(drops[k]);
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL en_drop_qualify: busy got %b want 1", busy); end
         enable = 1'b0;
         ticks(1);
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_drop_idle: busy got %b want 0", busy); end
         piezo_in = 1'b0;
         ticks(4);
         enable = 1'b1;
         ticks(6);
         checks++; if (obs_cyc.size() != 0) begin errors++; $display("FAIL en_drop_strobe: got %0d strobes want 0", obs_cyc.size()); obs_cyc.delete(); obs_ts.delete(); end
         checks++; if (event_count !== exp_count) begin errors++; $display("FAIL en_drop_count: got %h want %h", event_count, exp_count); end
      end
   endtask

   task automatic test_clr_count;
      int unsigned c, e, o;
      logic [31:0] t;
      ticks(5);
      clr_count = 1'b1;
      ticks(1);
      clr_count = 1'b0;
      exp_count = '0;
      checks++; if (event_count !== exp_count) begin errors++; $display("FAIL clr_plain: got %h want %h", event_count, exp_count); end
      c = cyc;
      start_pulse(1'b1);
      ticks(SS + MH);
      clr_count = 1'b1;
      ticks(1);
      clr_count = 1'b0;
      exp_count = 16'd1;
      checks++; if (event_count !== exp_count) begin errors++; $display("FAIL clr_with_strobe: got %h want %h", event_count, exp_count); end
      ticks_to(c + 20); piezo_in = 1'b0;
      ticks_to(c + SS + MH + HO + 2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_cyc.size() == 0) begin
            errors++; $display("FAIL clr_strobe: missing, want edge %0d", e);
         end else begin
            o = obs_cyc.pop_front(); t = obs_ts.pop_front();
            if (o !== e) begin errors++; $display("FAIL clr_strobe: edge %0d want %0d", o, e); end
            checks++;
            if (t !== (TS_EN ? 32'(e - 1) : 32'd0)) begin errors++; $display("FAIL clr_ts: got %0d want %0d", t, TS_EN ? e - 1 : 0); end
         end
      end
      checks++; if (obs_cyc.size() != 0) begin errors++; $display("FAIL clr_extra: got %0d extra strobes want 0", obs_cyc.size()); obs_cyc.delete(); obs_ts.delete(); end
   endtask

   task automatic test_reset_midway;
      int unsigned e, o;
      logic [31:0] t;
      ticks(5);
      start_pulse(1'b1);
      ticks(15);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_cyc.size() == 0) begin
            errors++; $display("FAIL rst_hold_strobe: missing, want edge %0d", e);
         end else begin
            o = obs_cyc.pop_front(); t = obs_ts.pop_front();
            if (o !== e) begin errors++; $display("FAIL rst_hold_strobe: edge %0d want %0d", o, e); end
         end
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_hold_busy: got %b want 1", busy); end
      #2 reset_n = 1'b0;
      #1;
      exp_count = '0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", busy); end
      checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL rst_async_pulse: got %b want 0", pulse_out); end
      checks++; if (event_count !== exp_count) begin errors++; $display("FAIL rst_async_count: got %h want %h", event_count, exp_count); end
      checks++; if (timestamp !== 32'h0) begin errors++; $display("FAIL rst_async_ts: got %h want 0", timestamp); end
      piezo_in = 1'b0;
      ticks(2);
      reset_n = 1'b1;
      ticks(3);
      start_pulse(1'b0);
      ticks(6);
      #2 reset_n = 1'b0;
      piezo_in = 1'b0;
      ticks(2);
      reset_n = 1'b1;
      ticks(20);
      checks++; if (obs_cyc.size() != 0) begin errors++; $display("FAIL rst_qualify_strobe: got %0d strobes want 0", obs_cyc.size()); obs_cyc.delete(); obs_ts.delete(); end
      checks++; if (event_count !== exp_count) begin errors++; $display("FAIL rst_qualify_count: got %h want %h", event_count, exp_count); end
   endtask

   task automatic test_wrap;
      int unsigned n = 0;
      repeat (4) @(negedge clk2);
      for (int unsigned i = 0; i < 65535; i++) begin
         @(negedge clk2); piezo2 = 1'b1; if (pulse2) n++;
         @(negedge clk2); piezo2 = 1'b0; if (pulse2) n++;
      end
      repeat (8) @(negedge clk2) if (pulse2) n++;
      checks++; if (n != 65535) begin errors++; $display("FAIL wrap_pulses: got %0d want 65535", n); end
      checks++; if (count2 !== 16'hFFFF) begin errors++; $display("FAIL wrap_full: got %h want ffff", count2); end
      @(negedge clk2); piezo2 = 1'b1; if (pulse2) n++;
      @(negedge clk2); piezo2 = 1'b0; if (pulse2) n++;
      repeat (8) @(negedge clk2) if (pulse2) n++;
      checks++; if (n != 65536) begin errors++; $display("FAIL wrap_last_pulse: got %0d want 65536", n); end
      checks++; if (count2 !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", count2); end
   endtask

   initial begin
      test_reset;
      test_glitch;
      test_single_pulse;
      test_holdoff;
      test_enable_drop;
      test_clr_count;
      test_reset_midway;
      test_wrap;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule
